// File: rtl/rv_wb.sv
// -----------------------------------------------------------------------------
// rv_wb : write-back stage (Q104H) of the rv pipeline.
//
// Takes the registered pre-write-back value and the D_MEM read word from the
// memory-access stage, extracts/extends load data, selects the final
// write-back value and commits it to the 32-entry integer register file.
// The register file also serves the two decode-side (Q101H) read ports, which
// see a same-cycle write through a bypass. A retired-instruction counter and a
// sticky misaligned-load flag are kept alongside.
//
// Ports:
//   clk                clock, all state updates on the rising edge
//   rst                synchronous active-low reset
//   valid_Q104H        instruction in Q104H is valid
//   rd_we_Q104H        instruction writes rd
//   rd_addr_Q104H      destination register index
//   sel_ld_Q104H       1: write back load data, 0: pre_wb_data_Q104H
//   ld_funct3_Q104H    RV32I load funct3
//   addr_lsb_Q104H     byte offset of the load address
//   dmem_rdata_Q104H   aligned D_MEM read word
//   pre_wb_data_Q104H  PC+4 / ALU result
//   rs1_addr_Q101H     decode read port 1 address
//   rs2_addr_Q101H     decode read port 2 address
//   rs1_data_Q101H     decode read port 1 data
//   rs2_data_Q101H     decode read port 2 data
//   wb_data_Q104H      final write-back value (combinational)
//   retired_cnt        number of valid instructions retired
//   misaligned_err     sticky misaligned-load flag
// -----------------------------------------------------------------------------
module rv_wb #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_Q104H,
    input  logic             rd_we_Q104H,
    input  logic [4:0]       rd_addr_Q104H,
    input  logic             sel_ld_Q104H,
    input  logic [2:0]       ld_funct3_Q104H,
    input  logic [1:0]       addr_lsb_Q104H,
    input  logic [31:0]      dmem_rdata_Q104H,
    input  logic [31:0]      pre_wb_data_Q104H,
    input  logic [4:0]       rs1_addr_Q101H,
    input  logic [4:0]       rs2_addr_Q101H,
    output logic [31:0]      rs1_data_Q101H,
    output logic [31:0]      rs2_data_Q101H,
    output logic [31:0]      wb_data_Q104H,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             misaligned_err
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int NUM_RD_PORTS = 2;

    logic [31:0]      regs_reg [NUM_REGS];
    logic [CNT_W-1:0] retired_cnt_reg;
    logic             misaligned_err_reg;

    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;
    logic             misal;
    logic             we;

    // ------------------------------------------------------------------
    // Load lane extraction and extension
    // ------------------------------------------------------------------
    always_comb begin
        ld_byte = dmem_rdata_Q104H[8*addr_lsb_Q104H +: 8];
        ld_half = addr_lsb_Q104H[1] ? dmem_rdata_Q104H[31:16] : dmem_rdata_Q104H[15:0];
        case (ld_funct3_Q104H)
            F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_data = {24'd0, ld_byte};
            F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  ld_data = {16'd0, ld_half};
            F3_LW:   ld_data = dmem_rdata_Q104H;
            default: ld_data = 32'd0;
        endcase
    end

    // Only defined load types can be misaligned; unknown funct3 just yields 0.
    always_comb begin
        misal = 1'b0;
        if (sel_ld_Q104H && valid_Q104H) begin
            if ((ld_funct3_Q104H == F3_LH || ld_funct3_Q104H == F3_LHU) && addr_lsb_Q104H[0])
                misal = 1'b1;
            else if (ld_funct3_Q104H == F3_LW && addr_lsb_Q104H != 2'b00)
                misal = 1'b1;
        end
    end

    assign wb_data_Q104H = sel_ld_Q104H ? ld_data : pre_wb_data_Q104H;

    // rst gates the write so the bypass also goes quiet while in reset.
    assign we = valid_Q104H && rd_we_Q104H && (rd_addr_Q104H != 5'd0) && !misal && rst;

    // ------------------------------------------------------------------
    // Register file, counter and sticky flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= 32'd0;
            end
            retired_cnt_reg    <= '0;
            misaligned_err_reg <= 1'b0;
        end else begin
            if (we) begin
                regs_reg[rd_addr_Q104H] <= wb_data_Q104H;
            end
            if (valid_Q104H) begin
                retired_cnt_reg <= retired_cnt_reg + CNT_W'(1);
            end
            if (misal) begin
                misaligned_err_reg <= 1'b1;
            end
        end
    end

    assign retired_cnt    = retired_cnt_reg;
    assign misaligned_err = misaligned_err_reg;

    // ------------------------------------------------------------------
    // Decode read ports with write-through bypass
    // ------------------------------------------------------------------
    logic [4:0]  rd_port_addr [NUM_RD_PORTS];
    logic [31:0] rd_port_data [NUM_RD_PORTS];

    assign rd_port_addr[0] = rs1_addr_Q101H;
    assign rd_port_addr[1] = rs2_addr_Q101H;

    generate
        for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd_port
            always_comb begin
                if (rd_port_addr[gi] == 5'd0)
                    rd_port_data[gi] = 32'd0;
                else if (we && rd_port_addr[gi] == rd_addr_Q104H)
                    rd_port_data[gi] = wb_data_Q104H;
                else
                    rd_port_data[gi] = regs_reg[rd_port_addr[gi]];
            end
        end
    endgenerate

    assign rs1_data_Q101H = rd_port_data[0];
    assign rs2_data_Q101H = rd_port_data[1];

endmodule
